register_file: RTL and testbench
================================

# register_file

- Architectural register file with ROB rename tags; sits downstream of the reorder buffer.
- Retires committed results (`rd`, value, ROB id) into 32 × 32-bit registers.
- Records which ROB entry will produce each register when the instruction unit dispatches.
- Serves two combinational source-operand reads, returning either a ready value or a pending ROB tag, to the instruction unit and reservation stations.

## Interface
Parameters:
- `REG_NUM`, 32, number of architectural registers; x0 is hardwired zero.
- `ROB_INDEX_BIT`, from `const.v`, width of ROB tags.

Ports:
- `clk_in`  in  1  clock.
- `rst_in`  in  1  reset; **synchronous, active-high**.
- `rdy_in`  in  1  when low, no state changes.
- `clear_in`  in  1  misprediction flush from the ROB.
- `issue_req`  in  1  a dispatch renames a destination this cycle.
- `issue_rd`  in  5  destination register of the dispatch.
- `issue_rob_id`  in  `ROB_INDEX_BIT`  ROB tail slot allocated to the dispatch.
- `commit_rd`  in  5  committing destination; 0 means no commit.
- `commit_val`  in  32  committed value, including the JALR link value.
- `commit_rob_id`  in  `ROB_INDEX_BIT`  ROB head slot being committed.
- `rs1_idx`, `rs2_idx`  in  5  source register indices.
- `rs1_val`, `rs2_val`  out  32  register value; valid only when the matching `has_dep` is 0.
- `rs1_has_dep`, `rs2_has_dep`  out  1  1 when the source awaits an ROB entry.
- `rs1_dep`, `rs2_dep`  out  `ROB_INDEX_BIT`  producing ROB id when `has_dep` is 1; otherwise 0.

## Operation
State per register: `val[32]`, `busy[1]`, `tag[ROB_INDEX_BIT]`.

Commit (`commit_rd != 0`):
- Write `val[commit_rd] <= commit_val`.
- If `busy[commit_rd]` and `tag == commit_rob_id`, clear `busy`.
- If the tag differs, a younger writer is pending: the value is written and `busy`/`tag` are kept.

Issue (`issue_req && issue_rd != 0 && !clear_in`):
- Set `busy[issue_rd] <= 1` and `tag[issue_rd] <= issue_rob_id`.

Simultaneous commit and issue to the same `rd`:
- The value is written.
- Issue wins `busy`/`tag`, so the register stays busy with the new tag.

Clear:
- Committed values are retained.
- Every `busy` bit is cleared.
- Issue is ignored in that cycle.
- A commit in the same cycle still writes its value.

Reads (combinational, per port):
- `idx == 0` → value 0, no dependency.
- `busy` is 0 → `val`, no dependency.
- `busy` is 1 and `commit_rd == idx` and `tag == commit_rob_id` → bypass: `commit_val` with no dependency.
- Otherwise → `has_dep = 1`, `dep = tag`.

Read ordering and x0:
- Reads observe state before this cycle's issue, so an instruction whose `rs == rd` reads the older producer.
- Writes to x0 are discarded; `val[0]` is always 0.

## Timing
- Reset: all `val`, `busy`, and `tag` are 0.
- Every read output then yields value 0, `has_dep` 0, `dep` 0.
- Read latency: 0 cycles, combinational from the indices and commit inputs.
- Commit and issue take effect at the next `posedge clk_in`.
- `rdy_in` low: commit, issue, and clear are all ignored. Reads remain combinational on the held state; the bypass still follows the commit inputs.
- Reset has priority over clear; clear has priority over issue.
- Reset mid-operation drops all pending tags in one cycle.

## Configuration
Macro `RF_DBG_EN`.
- Defined: adds output `dbg_a0` (32, live `val[10]`).
- Defined: adds output `dbg_write_cnt` (32, counts accepted nonzero commits; reset 0; holds while `rdy_in` is low).
- Undefined: neither port nor the counter exists; behaviour is otherwise identical.

## Structure
- `REG_NUM`, `ROB_INDEX_BIT`, and `ROB_CAP` live in the shared `const.v`.
- One sub-module, `rf_read_port`: the combinational lookup and bypass, instantiated twice.

## Test plan
- Reset, then read x5 and x0 → both return value 0 with `has_dep` 0.
- Issue rd=5 with ROB id 3; next cycle read x5 → `has_dep` 1, `dep` 3; commit rd=5, val 0xDEAD, id 3 → same-cycle read gives 0xDEAD with no dependency; next cycle, registered value 0xDEAD.
- Issue rd=7 with id 2, then rd=7 with id 4; commit rd=7, id 2, val 11 → read x7 still `dep` 4 with `val[7] = 11`; commit id 4, val 22 → x7 ready with value 22.
- Same cycle: commit rd=9 with id 1 and issue rd=9 with id 6 → next cycle `val[9]` is updated, `has_dep` 1, `dep` 6.
- Issue rd=3 and rd=4, then assert `clear_in` with a concurrent issue rd=8 → all `busy` cleared, x8 not renamed, old values kept.
- Hold `rdy_in` low with commit and issue active → no register change; release it → operations resume.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and sizes for the architectural register file.
// Holds REG_NUM, ROB_INDEX_BIT and ROB_CAP plus the word/index/tag types.
package register_file_pkg;

   localparam int REG_NUM       = 32;
   localparam int ROB_INDEX_BIT = 4;
   localparam int ROB_CAP       = 1 << ROB_INDEX_BIT;

   typedef logic [31:0]              word_t;
   typedef logic [4:0]               reg_idx_t;
   typedef logic [ROB_INDEX_BIT-1:0] rob_id_t;

   typedef logic [REG_NUM-1:0][31:0]              val_arr_t;
   typedef logic [REG_NUM-1:0]                    busy_arr_t;
   typedef logic [REG_NUM-1:0][ROB_INDEX_BIT-1:0] tag_arr_t;

endpackage

// File: rtl/register_file_if.sv
// Bus between ROB / instruction unit (master) and the register file (slave).
// Carries rdy/clear, dispatch rename, commit and the two operand read ports.
interface register_file_if;
   import register_file_pkg::*;

   logic     rdy_in;
   logic     clear_in;
   logic     issue_req;
   reg_idx_t issue_rd;
   rob_id_t  issue_rob_id;
   reg_idx_t commit_rd;
   word_t    commit_val;
   rob_id_t  commit_rob_id;
   reg_idx_t rs1_idx;
   reg_idx_t rs2_idx;
   word_t    rs1_val;
   word_t    rs2_val;
   logic     rs1_has_dep;
   logic     rs2_has_dep;
   rob_id_t  rs1_dep;
   rob_id_t  rs2_dep;

   modport master (
      output rdy_in, clear_in,
      output issue_req, issue_rd, issue_rob_id,
      output commit_rd, commit_val, commit_rob_id,
      output rs1_idx, rs2_idx,
      input  rs1_val, rs2_val,
      input  rs1_has_dep, rs2_has_dep,
      input  rs1_dep, rs2_dep
   );

   modport slave (
      input  rdy_in, clear_in,
      input  issue_req, issue_rd, issue_rob_id,
      input  commit_rd, commit_val, commit_rob_id,
      input  rs1_idx, rs2_idx,
      output rs1_val, rs2_val,
      output rs1_has_dep, rs2_has_dep,
      output rs1_dep, rs2_dep
   );

endinterface

// File: rtl/register_file_rf_read_port.sv
// rf_read_port: combinational operand lookup with commit bypass.
// In: idx, register state arrays, commit inputs. Out: val, has_dep, dep.
module rf_read_port
   import register_file_pkg::*;
(
   input  reg_idx_t  idx,
   input  val_arr_t  val,
   input  busy_arr_t busy,
   input  tag_arr_t  tag,
   input  reg_idx_t  commit_rd,
   input  word_t     commit_val,
   input  rob_id_t   commit_rob_id,
   output word_t     val_o,
   output logic      has_dep,
   output rob_id_t   dep
);

   always_comb begin
      val_o   = '0;
      has_dep = 1'b0;
      dep     = '0;
      if (idx != '0) begin
         if (!busy[idx]) begin
            val_o = val[idx];
         end else if (commit_rd == idx &&
                      tag[idx] == commit_rob_id) begin
            // producer is retiring right now
            val_o = commit_val;
         end else begin
            has_dep = 1'b1;
            dep     = tag[idx];
         end
      end
   end

endmodule

// File: rtl/register_file.sv
// Architectural register file with ROB rename tags and two read ports.
// Ports: clk_in, rst_in (sync, active-high), bus (slave modport);
// with RF_DBG_EN defined also dbg_a0 and dbg_write_cnt outputs.
module register_file
   import register_file_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_in,
   register_file_if.slave   bus
`ifdef RF_DBG_EN
   ,
   output word_t            dbg_a0,
   output logic [31:0]      dbg_write_cnt
`endif
);

   val_arr_t  val_q, val_d;
   busy_arr_t busy_q, busy_d;
   tag_arr_t  tag_q, tag_d;

   logic commit_en;
   assign commit_en = bus.rdy_in && (bus.commit_rd != '0);

   always_comb begin
      val_d  = val_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (bus.rdy_in) begin
         if (commit_en) begin
            val_d[bus.commit_rd] = bus.commit_val;
            // a younger rename keeps the register busy
            if (busy_q[bus.commit_rd] &&
                tag_q[bus.commit_rd] == bus.commit_rob_id)
               busy_d[bus.commit_rd] = 1'b0;
         end
         if (bus.clear_in) begin
            busy_d = '0;
         end else if (bus.issue_req && bus.issue_rd != '0) begin
            busy_d[bus.issue_rd] = 1'b1;
            tag_d[bus.issue_rd]  = bus.issue_rob_id;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         val_q  <= '0;
         busy_q <= '0;
         tag_q  <= '0;
      end else begin
         val_q  <= val_d;
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   end

   rf_read_port u_rs1 (
      .idx           (bus.rs1_idx),
      .val           (val_q),
      .busy          (busy_q),
      .tag           (tag_q),
      .commit_rd     (bus.commit_rd),
      .commit_val    (bus.commit_val),
      .commit_rob_id (bus.commit_rob_id),
      .val_o         (bus.rs1_val),
      .has_dep       (bus.rs1_has_dep),
      .dep           (bus.rs1_dep)
   );

   rf_read_port u_rs2 (
      .idx           (bus.rs2_idx),
      .val           (val_q),
      .busy          (busy_q),
      .tag           (tag_q),
      .commit_rd     (bus.commit_rd),
      .commit_val    (bus.commit_val),
      .commit_rob_id (bus.commit_rob_id),
      .val_o         (bus.rs2_val),
      .has_dep       (bus.rs2_has_dep),
      .dep           (bus.rs2_dep)
   );

`ifdef RF_DBG_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (commit_en)
         cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign dbg_a0        = val_q[10];
   assign dbg_write_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with an array-based reference model.
// Model checked on every negedge; literal checks pin key scenarios.
module tb_register_file;
   import register_file_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   bit   live = 1'b0;

`ifdef RF_DBG_EN
   word_t       dbg_a0;
   logic [31:0] dbg_write_cnt;
`endif

   register_file_if bus ();

   register_file dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
`ifdef RF_DBG_EN
      ,
      .dbg_a0        (dbg_a0),
      .dbg_write_cnt (dbg_write_cnt)
`endif
   );

   always #5 clk = ~clk;

   // reference state: last retired value and pending producer per register
   word_t   m_val [32];
   bit      m_pend [32];
   rob_id_t m_prod [32];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_pend[i] = 0; m_prod[i] = 0;
         end
      end else if (bus.rdy_in) begin
         if (bus.commit_rd != 0) begin
            m_val[bus.commit_rd] = bus.commit_val;
            if (m_pend[bus.commit_rd] &&
                m_prod[bus.commit_rd] == bus.commit_rob_id)
               m_pend[bus.commit_rd] = 0;
         end
         if (bus.clear_in) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
         end else if (bus.issue_req && bus.issue_rd != 0) begin
            m_pend[bus.issue_rd] = 1;
            m_prod[bus.issue_rd] = bus.issue_rob_id;
         end
      end
   end

   function automatic logic [36:0] model_rd(input int r);
      // {has_dep, dep, val}
      if (r == 0) return '0;
      if (!m_pend[r]) return {1'b0, 4'd0, m_val[r]};
      if (bus.commit_rd == r && bus.commit_rob_id == m_prod[r])
         return {1'b0, 4'd0, bus.commit_val};
      return {1'b1, m_prod[r], 32'd0};
   endfunction

   always @(negedge clk) begin
      if (live && !rst) begin
         logic [36:0] e1, e2;
         e1 = model_rd(int'(bus.rs1_idx));
         e2 = model_rd(int'(bus.rs2_idx));
         tests++;
         if ({bus.rs1_has_dep, bus.rs1_dep, bus.rs1_val} != e1) begin
            fails++;
            $display("FAIL model_rs1 t=%0t got %h want %h", $time,
                     {bus.rs1_has_dep, bus.rs1_dep, bus.rs1_val}, e1);
         end
         tests++;
         if ({bus.rs2_has_dep, bus.rs2_dep, bus.rs2_val} != e2) begin
            fails++;
            $display("FAIL model_rs2 t=%0t got %h want %h", $time,
                     {bus.rs2_has_dep, bus.rs2_dep, bus.rs2_val}, e2);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h want %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.clear_in  = 0;
      bus.issue_req = 0;
      bus.issue_rd  = 0;
      bus.issue_rob_id = 0;
      bus.commit_rd = 0;
      bus.commit_val = 0;
      bus.commit_rob_id = 0;
   endtask

   task automatic issue(input int rd, input int id);
      bus.issue_req = 1;
      bus.issue_rd = 5'(rd);
      bus.issue_rob_id = 4'(id);
   endtask

   task automatic commit(input int rd, input word_t v, input int id);
      bus.commit_rd = 5'(rd);
      bus.commit_val = v;
      bus.commit_rob_id = 4'(id);
   endtask

   task automatic rd1(input string n, input logic hd,
                      input int dep, input word_t v);
      #1;
      chk({n, "_hd"}, 32'(bus.rs1_has_dep), 32'(hd));
      chk({n, "_dep"}, 32'(bus.rs1_dep), 32'(dep));
      chk({n, "_val"}, bus.rs1_val, v);
   endtask

   task automatic rd2(input string n, input logic hd,
                      input int dep, input word_t v);
      #1;
      chk({n, "_hd"}, 32'(bus.rs2_has_dep), 32'(hd));
      chk({n, "_dep"}, 32'(bus.rs2_dep), 32'(dep));
      chk({n, "_val"}, bus.rs2_val, v);
   endtask

   initial begin
      idle();
      bus.rdy_in = 1;
      bus.rs1_idx = 5;
      bus.rs2_idx = 0;
      rst = 1;
      step(); step();
      rst = 0;
      live = 1;
      rd1("rst_x5", 0, 0, 0);
      rd2("rst_x0", 0, 0, 0);

      issue(5, 3); step(); idle();
      rd1("dep_x5", 1, 3, 0);
      commit(5, 32'hDEAD, 3);
      rd1("byp_x5", 0, 0, 32'hDEAD);
      step(); idle();
      rd1("reg_x5", 0, 0, 32'hDEAD);

      bus.rs1_idx = 7;
      issue(7, 2); step();
      issue(7, 4); step(); idle();
      commit(7, 11, 2);
      rd1("old_x7", 1, 4, 0);
      step(); idle();
      rd1("young_x7", 1, 4, 0);
      commit(7, 22, 4);
      rd1("byp_x7", 0, 0, 22);
      step(); idle();
      rd1("ready_x7", 0, 0, 22);

      bus.rs1_idx = 9;
      commit(9, 32'h99, 1); issue(9, 6);
      rd1("pre_x9", 0, 0, 0);
      step(); idle();
      rd1("ren_x9", 1, 6, 0);

      bus.rs1_idx = 3; bus.rs2_idx = 8;
      issue(3, 5); step();
      issue(4, 7); step(); idle();
      rd1("busy_x3", 1, 5, 0);
      bus.clear_in = 1; issue(8, 8);
      step(); idle();
      rd1("clr_x3", 0, 0, 0);
      rd2("clr_x8", 0, 0, 0);
      bus.rs1_idx = 9; bus.rs2_idx = 7;
      rd1("clr_x9", 0, 0, 32'h99);
      rd2("clr_x7", 0, 0, 22);

      issue(10, 2); step(); idle();
      bus.rdy_in = 0;
      bus.rs1_idx = 10; bus.rs2_idx = 5;
      commit(10, 32'h55, 2);
      rd1("hold_byp", 0, 0, 32'h55);
      step();
      commit(5, 1, 0); issue(6, 9);
      step(); step();
      rd2("hold_x5", 0, 0, 32'hDEAD);
      bus.rs1_idx = 6;
      rd1("hold_x6", 0, 0, 0);
      bus.rdy_in = 1;
      step(); idle();
      rd1("go_x6", 1, 9, 0);
      rd2("go_x5", 0, 0, 1);
      bus.rs1_idx = 10;
      rd1("still_x10", 1, 2, 0);

      bus.rs1_idx = 0;
      issue(0, 5); step(); idle();
      rd1("x0_iss", 0, 0, 0);

      bus.rs1_idx = 11; bus.rs2_idx = 5;
      issue(11, 3); step(); idle();
      rd1("pre_rst", 1, 3, 0);
      rst = 1; step(); rst = 0;
      rd1("mid_rst_x11", 0, 0, 0);
      rd2("mid_rst_x5", 0, 0, 0);
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
